capture_seq: RTL and testbench
==============================

// Module: capture_seq
// PURPOSE
//  Sequences the datagen sampler for DMA capture runs: latches a run config on start, drives
//  en_ctr/en_sample/frame_size/delay, acknowledges each frame's done with a clr pulse and counts
//  frames by snooping the generator's AXI-Stream tlast handshake. Stops after N frames, on abort
//  or on a watchdog timeout. Sits between the PS-side control registers and datagen.
// PARAMETERS
//  CNT_W  16  width of frame-count config and frames_done counter
//  TO_W   32  width of watchdog timeout config/counter
// PORTS
//  clk             in   1      clock
//  nrst            in   1      reset, synchronous, active-low
//  start           in   1      run request pulse; ignored while busy
//  abort           in   1      stop request; ends run at next frame boundary or immediately if idle-phase
//  cfg_frames      in   CNT_W  frames per run; 0 = continuous until abort
//  cfg_frame_size  in   8      samples per frame (0 = 256, datagen wrap semantics)
//  cfg_delay       in   32     inter-frame delay in cycles, passed to datagen
//  cfg_timeout     in   TO_W   watchdog limit in cycles per phase; 0 = disabled
//  gen_en_ctr      out  1      datagen counter enable
//  gen_en_sample   out  1      datagen sampling enable
//  gen_frame_size  out  8      registered frame size to datagen
//  gen_delay       out  32     registered delay to datagen
//  gen_clr         out  1      one-cycle done acknowledge to datagen
//  gen_done        in   1      datagen done flag
//  snp_tvalid      in   1      snooped m_axis_tvalid
//  snp_tready      in   1      snooped m_axis_tready
//  snp_tlast       in   1      snooped m_axis_tlast
//  busy            out  1      run in progress
//  frames_done     out  CNT_W  frames completed this run (wraps mod 2^CNT_W)
//  err_timeout     out  1      sticky watchdog error, cleared by next accepted start
//  irq             out  1      one-cycle pulse at run end (normal, abort or timeout)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; timeout counter 0; abort_pend 0.
//  fend = snp_tvalid & snp_tready & snp_tlast (frame-end handshake).
//  States (2-bit): IDLE, RUN (await gen_done), STREAM (await fend).
//  IDLE: busy=0, gen_en_sample=0, gen_en_ctr=0. start & !abort -> latch cfg_frame_size/cfg_delay
//   into gen_* (held constant until next start), frames_left<=cfg_frames, frames_done<=0,
//   err_timeout<=0, go RUN. start & abort same cycle -> stay IDLE, no irq.
//  RUN: busy=1, gen_en_ctr=1, gen_en_sample=!last_or_stop, where last_or_stop = abort_pend |
//   (cfg_frames!=0 & frames_left==1 & gen_done seen). On gen_done=1: gen_clr=1 next cycle (exactly one
//   cycle), go STREAM; if final frame, drop gen_en_sample in that same transition.
//   gen_done & fend same cycle (1-sample frame, tready=1): count frame directly, gen_clr still
//   pulsed once, go per STREAM exit rules without entering STREAM.
//   abort in RUN before gen_done -> drop gen_en_sample, go IDLE, irq=1 next cycle.
//  STREAM: gen_en_sample held as in RUN; abort sets abort_pend (en_sample drops, stream completes).
//   On fend: frames_done+=1, frames_left-=1 (not in continuous mode). Then
//   frames_left reaches 0 (cfg_frames!=0) or abort_pend -> IDLE, irq=1; else -> RUN.
//  Watchdog: counter clears on every state change; increments in RUN/STREAM; when cfg_timeout!=0
//   and counter==cfg_timeout-1 -> err_timeout=1, gen_en_sample=0, go IDLE, irq=1. Timeout wins over
//   gen_done/fend arriving same cycle (frame not counted).
//  busy falls and irq pulses the cycle after the terminating event; busy registered, no comb paths
//   from snp_* to outputs.
//  Reset mid-run: immediate return to reset values; no irq.
// TESTING
//  cfg_frames=3,size=4,delay=2,tready=1,start -> 3 fend, 3 gen_clr pulses, frames_done=3, one irq, busy 0 after 3rd tlast
//  Same cfg, tready toggling 1-of-3 cycles -> frames_done=3, gen_en_sample low from 3rd done to end, no extra frames sampled
//  cfg_frames=0,CNT_W=4, run 18 frames then abort in STREAM -> frame completes, frames_done=2 (wrapped), irq once
//  cfg_timeout=100, tready=0 held -> err_timeout=1 exactly 100 cycles after entering STREAM, irq, busy 0; next start clears err
//  cfg_frame_size=1,tready=1 -> gen_done and fend coincide each frame; counts correct, one gen_clr per frame
//  start while busy and start&abort in IDLE -> ignored; nrst low mid-STREAM -> all outputs 0 next cycle, no irq

Source files
------------

// File: rtl/capture_seq.sv
// rtl/capture_seq.sv - run sequencer for the datagen sampler: config latch, frame counting, abort and watchdog.
// Counts frames on the snooped tlast handshake and acknowledges each datagen done with a one-cycle clr.
module capture_seq #(
  parameter int CNT_W = 16,
  parameter int TO_W  = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [7:0]       cfg_frame_size,
  input  logic [31:0]      cfg_delay,
  input  logic [TO_W-1:0]  cfg_timeout,
  output logic             gen_en_ctr,
  output logic             gen_en_sample,
  output logic [7:0]       gen_frame_size,
  output logic [31:0]      gen_delay,
  output logic             gen_clr,
  input  logic             gen_done,
  input  logic             snp_tvalid,
  input  logic             snp_tready,
  input  logic             snp_tlast,
  output logic             busy,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_timeout,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frames_left;
  logic             continuous;
  logic             abort_pend;
  logic [TO_W-1:0]  wd_cnt;

  logic fend;
  logic done_ok;
  logic wd_hit;
  logic final_frame;

  assign fend        = snp_tvalid & snp_tready & snp_tlast;
  // datagen still shows done in the cycle clr is asserted; that stale level must not start a new frame
  assign done_ok     = gen_done & ~gen_clr;
  assign wd_hit      = (cfg_timeout != '0) && (wd_cnt == cfg_timeout - TO_W'(1));
  assign final_frame = ~continuous && (frames_left == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state          <= IDLE;
      frames_left    <= '0;
      continuous     <= 1'b0;
      abort_pend     <= 1'b0;
      wd_cnt         <= '0;
      gen_en_ctr     <= 1'b0;
      gen_en_sample  <= 1'b0;
      gen_frame_size <= '0;
      gen_delay      <= '0;
      gen_clr        <= 1'b0;
      busy           <= 1'b0;
      frames_done    <= '0;
      err_timeout    <= 1'b0;
      irq            <= 1'b0;
    end else begin
      gen_clr <= 1'b0;
      irq     <= 1'b0;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (start && !abort) begin
            gen_frame_size <= cfg_frame_size;
            gen_delay      <= cfg_delay;
            frames_left    <= cfg_frames;
            continuous     <= (cfg_frames == '0);
            frames_done    <= '0;
            err_timeout    <= 1'b0;
            abort_pend     <= 1'b0;
            busy           <= 1'b1;
            gen_en_ctr     <= 1'b1;
            gen_en_sample  <= 1'b1;
            state          <= RUN;
          end
        end

        RUN: begin
          if (wd_hit) begin
            err_timeout   <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
            gen_en_ctr    <= 1'b0;
            gen_en_sample <= 1'b0;
            abort_pend    <= 1'b0;
            wd_cnt        <= '0;
            irq           <= 1'b1;
          end else if (done_ok) begin
            gen_clr <= 1'b1;
            wd_cnt  <= '0;
            if (fend) begin
              // single-sample frame: done and tlast coincide, count without visiting STREAM
              frames_done <= frames_done + CNT_W'(1);
              if (!continuous) frames_left <= frames_left - CNT_W'(1);
              if (final_frame || abort) begin
                state         <= IDLE;
                busy          <= 1'b0;
                gen_en_ctr    <= 1'b0;
                gen_en_sample <= 1'b0;
                abort_pend    <= 1'b0;
                irq           <= 1'b1;
              end
            end else begin
              if (final_frame || abort) gen_en_sample <= 1'b0;
              abort_pend <= abort;
              state      <= STREAM;
            end
          end else if (abort) begin
            state         <= IDLE;
            busy          <= 1'b0;
            gen_en_ctr    <= 1'b0;
            gen_en_sample <= 1'b0;
            wd_cnt        <= '0;
            irq           <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
          end
        end

        STREAM: begin
          if (wd_hit) begin
            err_timeout   <= 1'b1;
            state         <= IDLE;
            busy          <= 1'b0;
            gen_en_ctr    <= 1'b0;
            gen_en_sample <= 1'b0;
            abort_pend    <= 1'b0;
            wd_cnt        <= '0;
            irq           <= 1'b1;
          end else if (fend) begin
            frames_done <= frames_done + CNT_W'(1);
            if (!continuous) frames_left <= frames_left - CNT_W'(1);
            wd_cnt <= '0;
            if (final_frame || abort_pend || abort) begin
              state         <= IDLE;
              busy          <= 1'b0;
              gen_en_ctr    <= 1'b0;
              gen_en_sample <= 1'b0;
              abort_pend    <= 1'b0;
              irq           <= 1'b1;
            end else begin
              state <= RUN;
            end
          end else begin
            wd_cnt <= wd_cnt + TO_W'(1);
            if (abort) begin
              abort_pend    <= 1'b1;
              gen_en_sample <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_capture_seq.sv
// tb/tb_capture_seq.sv - directed bench for capture_seq: cycle table plus multi-cycle run sequences.
// A second instance with CNT_W=4 exposes frames_done wrap in continuous mode.
module tb_capture_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst, start, abort, gen_done, snp_tvalid, snp_tready, snp_tlast;
  logic [15:0] cfg_frames;
  logic [7:0]  cfg_frame_size;
  logic [31:0] cfg_delay, cfg_timeout;

  logic        gen_en_ctr, gen_en_sample, gen_clr, busy, err_timeout, irq;
  logic [7:0]  gen_frame_size;
  logic [31:0] gen_delay;
  logic [15:0] frames_done;

  logic        en_ctr4, en_sample4, clr4, busy4, err4, irq4;
  logic [7:0]  frame_size4;
  logic [31:0] delay4;
  logic [3:0]  frames_done4;

  capture_seq dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .cfg_frames(cfg_frames), .cfg_frame_size(cfg_frame_size), .cfg_delay(cfg_delay),
    .cfg_timeout(cfg_timeout), .gen_en_ctr(gen_en_ctr), .gen_en_sample(gen_en_sample),
    .gen_frame_size(gen_frame_size), .gen_delay(gen_delay), .gen_clr(gen_clr),
    .gen_done(gen_done), .snp_tvalid(snp_tvalid), .snp_tready(snp_tready),
    .snp_tlast(snp_tlast), .busy(busy), .frames_done(frames_done),
    .err_timeout(err_timeout), .irq(irq)
  );

  capture_seq #(.CNT_W(4), .TO_W(32)) dut4 (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .cfg_frames(cfg_frames[3:0]), .cfg_frame_size(cfg_frame_size), .cfg_delay(cfg_delay),
    .cfg_timeout(cfg_timeout), .gen_en_ctr(en_ctr4), .gen_en_sample(en_sample4),
    .gen_frame_size(frame_size4), .gen_delay(delay4), .gen_clr(clr4),
    .gen_done(gen_done), .snp_tvalid(snp_tvalid), .snp_tready(snp_tready),
    .snp_tlast(snp_tlast), .busy(busy4), .frames_done(frames_done4),
    .err_timeout(err4), .irq(irq4)
  );

  int checks = 0;
  int failures = 0;
  int clr_cnt = 0;
  int irq_cnt = 0;
  int irq4_cnt = 0;
  int samp_hi = 0;

  always @(negedge clk) begin
    if (gen_clr) clr_cnt <= clr_cnt + 1;
    if (irq)     irq_cnt <= irq_cnt + 1;
    if (irq4)    irq4_cnt <= irq4_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "bench stopped by global time limit");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one frame: done held until clr is seen, then a stream of beats with tready every period cycles
  task automatic frame(input int beats, input int period, input bit last);
    int sent;
    int cyc;
    step();
    gen_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (gen_clr) break;
    end
    gen_done = 1'b0;
    if (!gen_clr) chk("clr_wait_expired", 64'(gen_clr), 64'd1);
    sent = 0;
    cyc = 0;
    snp_tvalid = 1'b1;
    while (sent < beats && cyc < 200) begin
      snp_tlast  = (sent == beats - 1);
      snp_tready = ((cyc % period) == 0);
      step();
      if (snp_tready) sent++;
      if (last && gen_en_sample) samp_hi++;
      cyc++;
    end
    snp_tvalid = 1'b0;
    snp_tlast  = 1'b0;
    snp_tready = 1'b0;
    if (sent < beats) chk("stream_wait_expired", 64'(sent), 64'(beats));
  endtask

  typedef struct {
    logic [5:0]  in;   // start, abort, gen_done, tvalid, tready, tlast
    logic [4:0]  exp;  // busy, en_ctr, en_sample, clr, irq
    logic [15:0] fd;
  } vec_t;

  vec_t vt[13];

  initial begin
    int b_clr, b_irq, b_irq4;

    vt[0]  = '{6'b100000, 5'b11100, 16'd0};
    vt[1]  = '{6'b000000, 5'b11100, 16'd0};
    vt[2]  = '{6'b001000, 5'b11110, 16'd0};
    vt[3]  = '{6'b001110, 5'b11100, 16'd0};
    vt[4]  = '{6'b000111, 5'b11100, 16'd1};
    vt[5]  = '{6'b000000, 5'b11100, 16'd1};
    vt[6]  = '{6'b001000, 5'b11010, 16'd1};
    vt[7]  = '{6'b000101, 5'b11000, 16'd1};
    vt[8]  = '{6'b000111, 5'b00001, 16'd2};
    vt[9]  = '{6'b110000, 5'b00000, 16'd2};
    vt[10] = '{6'b100000, 5'b11100, 16'd0};
    vt[11] = '{6'b010000, 5'b00001, 16'd0};
    vt[12] = '{6'b000000, 5'b00000, 16'd0};

    nrst = 1'b0; start = 1'b0; abort = 1'b0; gen_done = 1'b0;
    snp_tvalid = 1'b0; snp_tready = 1'b0; snp_tlast = 1'b0;
    cfg_frames = 16'd2; cfg_frame_size = 8'd4; cfg_delay = 32'd2; cfg_timeout = 32'd0;
    step(); step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_en_ctr", 64'(gen_en_ctr), 64'd0);
    chk("rst_en_sample", 64'(gen_en_sample), 64'd0);
    chk("rst_clr", 64'(gen_clr), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_frames_done", 64'(frames_done), 64'd0);
    chk("rst_frame_size", 64'(gen_frame_size), 64'd0);
    chk("rst_delay", 64'(gen_delay), 64'd0);
    chk("rst_err", 64'(err_timeout), 64'd0);
    nrst = 1'b1;
    step();

    for (int i = 0; i < 13; i++) begin
      {start, abort, gen_done, snp_tvalid, snp_tready, snp_tlast} = vt[i].in;
      step();
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(vt[i].exp[4]));
      chk($sformatf("tbl%0d_en_ctr", i), 64'(gen_en_ctr), 64'(vt[i].exp[3]));
      chk($sformatf("tbl%0d_en_sample", i), 64'(gen_en_sample), 64'(vt[i].exp[2]));
      chk($sformatf("tbl%0d_clr", i), 64'(gen_clr), 64'(vt[i].exp[1]));
      chk($sformatf("tbl%0d_irq", i), 64'(irq), 64'(vt[i].exp[0]));
      chk($sformatf("tbl%0d_frames_done", i), 64'(frames_done), 64'(vt[i].fd));
    end
    {start, abort, gen_done, snp_tvalid, snp_tready, snp_tlast} = 6'b000000;
    step();

    // three-frame runs, tready always high and then one cycle in three
    for (int p = 1; p <= 3; p += 2) begin
      cfg_frames = 16'd3; cfg_frame_size = 8'd4; cfg_delay = 32'd2;
      b_clr = clr_cnt; b_irq = irq_cnt; samp_hi = 0;
      start = 1'b1; step(); start = 1'b0;
      chk($sformatf("run3p%0d_busy", p), 64'(busy), 64'd1);
      chk($sformatf("run3p%0d_frame_size", p), 64'(gen_frame_size), 64'd4);
      chk($sformatf("run3p%0d_delay", p), 64'(gen_delay), 64'd2);
      for (int f = 0; f < 3; f++) frame(4, p, f == 2);
      chk($sformatf("run3p%0d_frames_done", p), 64'(frames_done), 64'd3);
      chk($sformatf("run3p%0d_busy_end", p), 64'(busy), 64'd0);
      chk($sformatf("run3p%0d_irq_end", p), 64'(irq), 64'd1);
      step(); step();
      chk($sformatf("run3p%0d_clr_pulses", p), 64'(clr_cnt - b_clr), 64'd3);
      chk($sformatf("run3p%0d_irq_pulses", p), 64'(irq_cnt - b_irq), 64'd1);
      chk($sformatf("run3p%0d_sample_after_last_done", p), 64'(samp_hi), 64'd0);
    end

    // one-sample frames: done and tlast handshake in the same cycle
    cfg_frames = 16'd3; cfg_frame_size = 8'd1;
    b_clr = clr_cnt; b_irq = irq_cnt;
    start = 1'b1; step(); start = 1'b0;
    chk("one_frame_size", 64'(gen_frame_size), 64'd1);
    for (int f = 0; f < 3; f++) begin
      step();
      {gen_done, snp_tvalid, snp_tready, snp_tlast} = 4'b1111;
      step();
      {gen_done, snp_tvalid, snp_tready, snp_tlast} = 4'b0000;
      chk($sformatf("one_f%0d_frames_done", f), 64'(frames_done), 64'(f + 1));
      chk($sformatf("one_f%0d_busy", f), 64'(busy), 64'(f < 2));
    end
    chk("one_irq_end", 64'(irq), 64'd1);
    step(); step();
    chk("one_clr_pulses", 64'(clr_cnt - b_clr), 64'd3);
    chk("one_irq_pulses", 64'(irq_cnt - b_irq), 64'd1);

    // continuous mode, abort during the 18th frame's stream; 4-bit counter wraps to 2
    cfg_frames = 16'd0; cfg_frame_size = 8'd2;
    b_irq = irq_cnt; b_irq4 = irq4_cnt;
    start = 1'b1; step(); start = 1'b0;
    for (int f = 0; f < 17; f++) frame(2, 1, 1'b0);
    chk("cont_17_busy", 64'(busy), 64'd1);
    chk("cont_17_frames_done4", 64'(frames_done4), 64'd1);
    step();
    gen_done = 1'b1; step(); gen_done = 1'b0;
    abort = 1'b1; snp_tvalid = 1'b1; snp_tready = 1'b0; snp_tlast = 1'b1;
    step(); abort = 1'b0;
    chk("cont_abort_busy", 64'(busy4), 64'd1);
    chk("cont_abort_en_sample", 64'(en_sample4), 64'd0);
    chk("cont_abort_irq", 64'(irq4), 64'd0);
    snp_tready = 1'b1;
    step();
    {snp_tvalid, snp_tready, snp_tlast} = 3'b000;
    chk("cont_end_busy", 64'(busy4), 64'd0);
    chk("cont_end_frames_done4", 64'(frames_done4), 64'd2);
    chk("cont_end_frames_done16", 64'(frames_done), 64'd18);
    step(); step();
    chk("cont_irq_pulses4", 64'(irq4_cnt - b_irq4), 64'd1);
    chk("cont_irq_pulses16", 64'(irq_cnt - b_irq), 64'd1);

    // watchdog in STREAM with tready stuck low; following start clears the sticky error
    cfg_frames = 16'd1; cfg_frame_size = 8'd4; cfg_timeout = 32'd100;
    start = 1'b1; step(); start = 1'b0;
    gen_done = 1'b1; step(); gen_done = 1'b0;
    chk("wd_enter_stream_clr", 64'(gen_clr), 64'd1);
    snp_tvalid = 1'b1; snp_tready = 1'b0; snp_tlast = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k == 99) begin
        chk("wd_99_err", 64'(err_timeout), 64'd0);
        chk("wd_99_busy", 64'(busy), 64'd1);
      end
    end
    chk("wd_100_err", 64'(err_timeout), 64'd1);
    chk("wd_100_busy", 64'(busy), 64'd0);
    chk("wd_100_irq", 64'(irq), 64'd1);
    chk("wd_100_en_sample", 64'(gen_en_sample), 64'd0);
    {snp_tvalid, snp_tready, snp_tlast} = 3'b000;
    cfg_timeout = 32'd0;
    step();
    chk("wd_err_sticky", 64'(err_timeout), 64'd1);
    start = 1'b1; step(); start = 1'b0;
    chk("wd_restart_err", 64'(err_timeout), 64'd0);
    chk("wd_restart_busy", 64'(busy), 64'd1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("wd_restart_abort_busy", 64'(busy), 64'd0);
    step();

    // start while busy is ignored; reset mid-stream clears everything without irq
    cfg_frames = 16'd2; cfg_frame_size = 8'd4; cfg_delay = 32'd7;
    start = 1'b1; step(); start = 1'b0;
    frame(4, 1, 1'b0);
    cfg_frame_size = 8'd9;
    start = 1'b1; step(); start = 1'b0;
    chk("busy_start_frames_done", 64'(frames_done), 64'd1);
    chk("busy_start_frame_size", 64'(gen_frame_size), 64'd4);
    chk("busy_start_busy", 64'(busy), 64'd1);
    gen_done = 1'b1; step(); gen_done = 1'b0;
    snp_tvalid = 1'b1; snp_tready = 1'b0;
    nrst = 1'b0; step(); nrst = 1'b1;
    snp_tvalid = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_en_ctr", 64'(gen_en_ctr), 64'd0);
    chk("mid_rst_en_sample", 64'(gen_en_sample), 64'd0);
    chk("mid_rst_clr", 64'(gen_clr), 64'd0);
    chk("mid_rst_irq", 64'(irq), 64'd0);
    chk("mid_rst_frames_done", 64'(frames_done), 64'd0);
    chk("mid_rst_frame_size", 64'(gen_frame_size), 64'd0);
    chk("mid_rst_delay", 64'(gen_delay), 64'd0);
    step();
    chk("post_rst_irq", 64'(irq), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
